// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Hazard and forwarding scoreboard for the pipelined RISC-V core. Tracks
//   in-flight register writes across DEPTH post-decode stages (0 = EX,
//   1 = MEM, 2 = WB for DEPTH=3). Each entry records the first stage whose
//   output carries the result. From that the block decides, per ID source
//   operand, whether to forward, read the register file, or stall decode.
//
// Ports
//   clk, rst            rising-edge clock; asynchronous active-low reset
//   id_valid            valid instruction in ID
//   id_rs1/id_rs2       source registers, qualified by id_rs*_used
//   id_rd/id_rd_we      destination register and its write enable
//   id_rdy              first tracked stage holding the result (ALU=0, load=1)
//   ext_stall           global freeze: all tracking state and stall_cnt hold
//   flush_mask          per-stage kill of the entries written at this edge
//   stall               hold PC and IF/ID, bubble into ID/EX (combinational)
//   fwd_sel1/fwd_sel2   0 = register file, k = forward from stage k-1
//   stall_cnt           wrapping count of cycles with stall=1 and ext_stall=0
module reg_scoreboard #(
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int SW    = 2,
  parameter int CW    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_rd_we,
  input  logic [SW-1:0]    id_rdy,
  input  logic             ext_stall,
  input  logic [DEPTH-1:0] flush_mask,
  output logic             stall,
  output logic [SW-1:0]    fwd_sel1,
  output logic [SW-1:0]    fwd_sel2,
  output logic [CW-1:0]    stall_cnt
);

  logic [DEPTH-1:0] v_q, v_d;
  logic [AW-1:0]    rd_q  [DEPTH];
  logic [AW-1:0]    rd_d  [DEPTH];
  logic [SW-1:0]    rdy_q [DEPTH];
  logic [SW-1:0]    rdy_d [DEPTH];
  logic [CW-1:0]    stall_cnt_q, stall_cnt_d;

  logic act1, act2, hit1, hit2, haz1, haz2;
  logic [SW-1:0] fwd1, fwd2;
  logic ins;

  // Hazard evaluation: scan from stage 0 so the youngest match wins. A
  // matching entry whose result is not yet produced (rdy > k) stalls decode.
  always_comb begin
    act1 = id_valid && id_rs1_used && (id_rs1 != '0);
    act2 = id_valid && id_rs2_used && (id_rs2 != '0);
    hit1 = 1'b0;
    hit2 = 1'b0;
    haz1 = 1'b0;
    haz2 = 1'b0;
    fwd1 = '0;
    fwd2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (act1 && !hit1 && v_q[k] && (rd_q[k] == id_rs1)) begin
        hit1 = 1'b1;
        if (rdy_q[k] <= SW'(k)) fwd1 = SW'(k + 1);
        else                    haz1 = 1'b1;
      end
      if (act2 && !hit2 && v_q[k] && (rd_q[k] == id_rs2)) begin
        hit2 = 1'b1;
        if (rdy_q[k] <= SW'(k)) fwd2 = SW'(k + 1);
        else                    haz2 = 1'b1;
      end
    end
  end

  assign stall     = haz1 | haz2;
  assign fwd_sel1  = fwd1;
  assign fwd_sel2  = fwd2;
  assign stall_cnt = stall_cnt_q;

  // x0 writes are never tracked; a stalled ID instruction enters as a bubble.
  assign ins = id_valid && id_rd_we && (id_rd != '0) && !stall;

  // Next state: shift the tracking pipe, then apply the per-stage kill.
  // Under ext_stall everything holds and flush_mask is ignored.
  always_comb begin
    v_d         = v_q;
    rd_d        = rd_q;
    rdy_d       = rdy_q;
    stall_cnt_d = stall_cnt_q;
    if (!ext_stall) begin
      for (int k = 1; k < DEPTH; k++) begin
        v_d[k]   = v_q[k-1] & ~flush_mask[k];
        rd_d[k]  = rd_q[k-1];
        rdy_d[k] = rdy_q[k-1];
      end
      v_d[0]      = ins & ~flush_mask[0];
      rd_d[0]     = id_rd;
      rdy_d[0]    = id_rdy;
      stall_cnt_d = stall_cnt_q + CW'(stall);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q         <= '0;
      stall_cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        rd_q[k]  <= '0;
        rdy_q[k] <= '0;
      end
    end else begin
      v_q         <= v_d;
      rd_q        <= rd_d;
      rdy_q       <= rdy_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
